instruction_fetch: RTL and testbench

Fetch stage of the 16-bit processor. The block owns the program counter and drives the instruction memory's combinational read address. It registers the returned 16-bit instruction together with its PC into an IF/ID output slot, which is handed to the decoder with a valid/ready handshake. It also handles start-up, branch redirect/flush, halt detection and PC wrap-around.

---
 rtl/instruction_fetch.sv | 79 +++++++
 tb/tb_instruction_fetch.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and
// registers instruction+PC into an IF/ID slot handed off with valid/ready.
module instruction_fetch #(
   parameter int          ADDR_DEPTH = 256,
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] HALT_INST  = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_inst,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_addr,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [15:0] if_inst,
   output logic [15:0] if_pc,
   output logic        halted,
   output logic [15:0] fetch_count
);

   localparam logic [15:0] AMASK = 16'(ADDR_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

   state_t      state, state_n;
   logic [15:0] pc;
   logic        free, accept, fetch, is_halt;

   assign free      = !if_valid || if_ready;
   assign accept    = if_valid && if_ready;
   assign fetch     = (state == RUN) && free && !redirect_valid;
   assign is_halt   = (imem_inst == HALT_INST);
   assign imem_addr = pc;
   assign halted    = (state == HALTED);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Redirect outranks start, so a redirect while idle keeps us idle.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start && !redirect_valid) state_n = RUN;
         RUN:     if (fetch && is_halt)         state_n = HALTED;
         HALTED:  if (redirect_valid)           state_n = RUN;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         if_valid <= 1'b0;
         if_inst  <= 16'h0000;
         if_pc    <= 16'h0000;
      end else if (redirect_valid) begin
         pc       <= redirect_addr & AMASK;
         if_valid <= 1'b0;
      end else if (fetch) begin
         if_inst  <= imem_inst;
         if_pc    <= pc;
         if_valid <= 1'b1;
         // The halt word is delivered but the PC parks on it.
         if (!is_halt) pc <= (pc + 16'd1) & AMASK;
      end else if (accept) begin
         if_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                                  fetch_count <= 16'h0000;
      else if (accept && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: start-up, backpressure, redirect,
// wrap, halt and mid-stream reset against hand-computed slot contents.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst, start, redirect_valid, if_ready;
   logic [15:0] redirect_addr;
   logic [15:0] imem_addr, imem_inst, if_inst, if_pc, fetch_count;
   logic        if_valid, halted;
   logic [15:0] mem [0:255];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   assign imem_inst = mem[imem_addr[7:0]];

   instruction_fetch dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_addr(imem_addr), .imem_inst(imem_inst),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_inst(if_inst), .if_pc(if_pc),
      .halted(halted), .fetch_count(fetch_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_slot(input string tag, input logic [15:0] pcx, input logic [15:0] inst);
      chk({tag, ".valid"}, {15'd0, if_valid}, 16'd1);
      chk({tag, ".pc"},    if_pc,   pcx);
      chk({tag, ".inst"},  if_inst, inst);
   endtask

   // Reset, start, and advance to the first valid slot (pc 0).
   task automatic go();
      rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; if_ready = 1'b1;
      step(); step();
      rst = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      chk("go.bubble", {15'd0, if_valid}, 16'd0);
      step();
      chk_slot("go.first", 16'h0000, 16'h0A4C);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h5000 + 16'(i);
      mem[0] = 16'h0A4C; mem[1] = 16'h069C; mem[2] = 16'h0298;
      rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_addr = 16'h0000; if_ready = 1'b1;
      step(); step();

      // Reset state
      chk("rst.valid", {15'd0, if_valid}, 16'd0);
      chk("rst.addr", imem_addr, 16'h0000);
      chk("rst.inst", if_inst, 16'h0000);
      chk("rst.pc", if_pc, 16'h0000);
      chk("rst.halted", {15'd0, halted}, 16'd0);
      chk("rst.count", fetch_count, 16'h0000);
      rst = 1'b0;
      step();
      chk("idle.valid", {15'd0, if_valid}, 16'd0);
      chk("idle.addr", imem_addr, 16'h0000);

      // Start-up and full throughput
      go();
      chk("A.count0", fetch_count, 16'd0);
      step(); chk_slot("A.s1", 16'h0001, 16'h069C); chk("A.count1", fetch_count, 16'd1);
      step(); chk_slot("A.s2", 16'h0002, 16'h0298); chk("A.count2", fetch_count, 16'd2);
      step(); chk_slot("A.s3", 16'h0003, 16'h5003); chk("A.count3", fetch_count, 16'd3);

      // Backpressure at pc 1
      go();
      step(); chk_slot("B.s1", 16'h0001, 16'h069C);
      if_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_slot("B.stall", 16'h0001, 16'h069C);
         chk("B.addr", imem_addr, 16'h0002);
      end
      chk("B.count_hold", fetch_count, 16'd1);
      if_ready = 1'b1;
      step(); chk_slot("B.release", 16'h0002, 16'h0298); chk("B.count", fetch_count, 16'd2);

      // Redirect while slot holds pc 4, accepted in the same cycle
      go();
      for (int k = 1; k <= 4; k++) step();
      chk_slot("C.s4", 16'h0004, 16'h5004);
      redirect_valid = 1'b1; redirect_addr = 16'h0010;
      step();
      redirect_valid = 1'b0;
      chk("C.flush", {15'd0, if_valid}, 16'd0);
      chk("C.addr", imem_addr, 16'h0010);
      chk("C.count_sim", fetch_count, 16'd5);
      step(); chk_slot("C.target", 16'h0010, 16'h5010); chk("C.count", fetch_count, 16'd5);

      // Wrap: FF then 00
      redirect_valid = 1'b1; redirect_addr = 16'h00FF;
      step();
      redirect_valid = 1'b0;
      chk("D.flush", {15'd0, if_valid}, 16'd0);
      step(); chk_slot("D.ff", 16'h00FF, 16'h50FF);
      step(); chk_slot("D.wrap", 16'h0000, 16'h0A4C);

      // Halt at pc 3
      mem[3] = 16'hFFFF;
      go();
      step(); step();
      chk("E.pre_halted", {15'd0, halted}, 16'd0);
      step();
      chk_slot("E.halt", 16'h0003, 16'hFFFF);
      chk("E.halted", {15'd0, halted}, 16'd1);
      chk("E.addr", imem_addr, 16'h0003);
      step();
      chk("E.drain", {15'd0, if_valid}, 16'd0);
      chk("E.still_halted", {15'd0, halted}, 16'd1);
      step();
      chk("E.no_fetch", {15'd0, if_valid}, 16'd0);
      chk("E.addr_hold", imem_addr, 16'h0003);
      chk("E.count", fetch_count, 16'd4);
      redirect_valid = 1'b1; redirect_addr = 16'h0000;
      step();
      redirect_valid = 1'b0;
      chk("E.resume", {15'd0, halted}, 16'd0);
      chk("E.resume_valid", {15'd0, if_valid}, 16'd0);
      step(); chk_slot("E.restart", 16'h0000, 16'h0A4C);
      mem[3] = 16'h5003;

      // Mid-stream reset at pc 7
      go();
      for (int k = 1; k <= 7; k++) step();
      chk_slot("F.s7", 16'h0007, 16'h5007);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("F.valid", {15'd0, if_valid}, 16'd0);
      chk("F.addr", imem_addr, 16'h0000);
      chk("F.count", fetch_count, 16'd0);
      chk("F.ifpc", if_pc, 16'h0000);
      step();
      chk("F.idle", {15'd0, if_valid}, 16'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      step(); chk_slot("F.restart", 16'h0000, 16'h0A4C);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
